dcache_ctrl: RTL

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_sram.sv | 51 +++++
 rtl/dcache_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Address field layout, FSM encoding and line-address helper.
package dcache_pkg;

  localparam int TAG_W    = 22;
  localparam int IDX_W    = 5;
  localparam int OFF_W    = 5;
  localparam int WSEL_W   = 3;
  localparam int TAG_LSB  = 10;
  localparam int IDX_LSB  = 5;
  localparam int WSEL_LSB = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILL    = 2'd3
  } state_e;

  function automatic logic [31:0] line_addr(
    input logic [TAG_W-1:0] tag,
    input logic [IDX_W-1:0] idx
  );
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag, valid, dirty and data storage for the data cache.
// One combinational read port, one synchronous write port.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic                 wr_dirty,
  input  logic [LINE_BITS-1:0] wr_line
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Payload arrays carry no reset; valid gates every use.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hit logic and the miss-handling FSM; storage lives in dcache_sram.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ack_i
);

  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_idx;
  logic [WSEL_W-1:0] cpu_wsel;
  logic              addr_unused;

  assign cpu_tag     = cpu_addr_i[TAG_LSB +: TAG_W];
  assign cpu_idx     = cpu_addr_i[IDX_LSB +: IDX_W];
  assign cpu_wsel    = cpu_addr_i[WSEL_LSB +: WSEL_W];
  assign addr_unused = ^cpu_addr_i[1:0];

  logic                 rd_valid;
  logic                 rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 wr_en;
  logic                 wr_dirty;
  logic [LINE_BITS-1:0] wr_line;
  logic [LINE_BITS-1:0] store_line;

  state_e state_q;
  logic   hit;
  logic   serve;
  logic   miss;
  logic   fill;

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_BITS (LINE_BITS)
  ) u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_idx   (cpu_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_idx   (cpu_idx),
    .wr_tag   (cpu_tag),
    .wr_dirty (wr_dirty),
    .wr_line  (wr_line)
  );

  // Every path into the array is gated by rst_i so a reset edge
  // abandons any in-flight access without touching the line.
  assign hit   = cpu_req_i && rd_valid && (rd_tag == cpu_tag);
  assign serve = rst_i && hit &&
                 (state_q == IDLE || state_q == REFILL);
  assign miss  = rst_i && cpu_req_i && !hit && (state_q == IDLE);
  assign fill  = rst_i && (state_q == ALLOCATE) && mem_ack_i;

  assign cpu_stall_o = miss ||
                       (rst_i && (state_q == WRITEBACK ||
                                  state_q == ALLOCATE));

  assign cpu_rdata_o = (serve && !cpu_we_i) ?
                       rd_line[32*cpu_wsel +: 32] : 32'h0;

  always_comb begin
    store_line = rd_line;
    store_line[32*cpu_wsel +: 32] = cpu_wdata_i;
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_dirty = 1'b0;
    wr_line  = mem_rdata_i;
    if (fill) begin
      wr_en = 1'b1;
    end else if (serve && cpu_we_i) begin
      wr_en    = 1'b1;
      wr_dirty = 1'b1;
      wr_line  = store_line;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (miss) begin
            mem_enable_o <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state_q     <= WRITEBACK;
              mem_write_o <= 1'b1;
              mem_addr_o  <= line_addr(rd_tag, cpu_idx);
              mem_wdata_o <= rd_line;
            end else begin
              state_q     <= ALLOCATE;
              mem_write_o <= 1'b0;
              mem_addr_o  <= line_addr(cpu_tag, cpu_idx);
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state_q     <= ALLOCATE;
            mem_write_o <= 1'b0;
            mem_addr_o  <= line_addr(cpu_tag, cpu_idx);
            mem_wdata_o <= '0;
          end
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            state_q      <= REFILL;
            mem_enable_o <= 1'b0;
            mem_addr_o   <= '0;
          end
        end
        REFILL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
